// File: rtl/filt_pkg.sv
// Shared definitions for the filter sample scheduler: filter select codes,
// FSM state encoding and the default sample width.
package filt_pkg;

    localparam int DEF_DATA_W = 16;

    localparam logic [1:0] FILT_SEL_LPF = 2'b00;
    localparam logic [1:0] FILT_SEL_HPF = 2'b01;
    localparam logic [1:0] FILT_SEL_BPF = 2'b10;
    localparam logic [1:0] FILT_SEL_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    // The reserved code leaves the current filter selected.
    function automatic logic [1:0] sel_next(input logic [1:0] cur, input logic [1:0] req);
        logic [1:0] r;
        r = cur;
        case (req)
            FILT_SEL_LPF, FILT_SEL_HPF, FILT_SEL_BPF: r = req;
            FILT_SEL_RSV:                             r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/filt_sched_if.sv
// Sample-in / filter / result-out signal bundle of the scheduler.
// master is the scheduler side, slave is the ADC + filter + consumer side.
interface filt_sched_if import filt_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              filt_start;
    logic [1:0]        filt_select;
    logic [DATA_W-1:0] filt_data;
    logic [DATA_W-1:0] filt_result;
    logic              filt_done;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;

    modport master (
        input  adc_data, adc_valid, filt_result, filt_done,
        output filt_start, filt_select, filt_data, out_data, out_valid
    );

    modport slave (
        output adc_data, adc_valid, filt_result, filt_done,
        input  filt_start, filt_select, filt_data, out_data, out_valid
    );
endinterface

// File: rtl/filt_sched_skid_hold.sv
// Single-entry sample hold with drop detection, sticky overrun flag and a
// saturating drop counter.
module skid_hold import filt_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              consume,
    input  logic              clr_status,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic              overrun,
    output logic [CNT_W-1:0]  drop_cnt
);
    logic take, accept, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign take   = adc_valid & enable;
    assign accept = take & (~full | consume);
    assign drop   = take & full & ~consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept)       full <= 1'b1;
            else if (consume) full <= 1'b0;
            // A drop in the same cycle as a clear restarts the count at one.
            if (drop) begin
                overrun  <= 1'b1;
                drop_cnt <= clr_status ? CNT_W'(1) : sat_inc(drop_cnt);
            end else if (clr_status) begin
                overrun  <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    // Payload is only observed while full is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) data <= adc_data;
    end
endmodule

// File: rtl/filt_sched.sv
// Sample scheduler in front of the filters datapath: issues one sample at a
// time, holds it stable until done, emits the result, and guards with a watchdog.
module filt_sched import filt_pkg::*; #(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        sel_req,
    input  logic              clr_status,
    filt_sched_if.master      bus,
    output logic              busy,
    output logic              overrun,
    output logic              timeout,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int SC_W = $clog2(START_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SC_W-1:0] ST_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_n;
    logic [SC_W-1:0]   st_cnt;
    logic [TO_W-1:0]   wd_cnt;
    logic              done_q, rise, start_done, wd_expire;
    logic              hold_full, consume;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] filt_data_r, out_data_r;
    logic [1:0]        filt_select_r;
    logic              out_valid_r;

    skid_hold #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .adc_valid  (bus.adc_valid),
        .adc_data   (bus.adc_data),
        .consume    (consume),
        .clr_status (clr_status),
        .full       (hold_full),
        .data       (hold_data),
        .overrun    (overrun),
        .drop_cnt   (drop_cnt)
    );

    // Done edges are only meaningful while waiting on the filter.
    assign rise       = (state == ST_WAIT) && !done_q && bus.filt_done;
    assign start_done = (st_cnt == ST_LAST);
    assign wd_expire  = (wd_cnt == WD_LAST);

    always_comb begin
        state_n = state;
        consume = 1'b0;
        unique case (state)
            ST_IDLE:  if (hold_full) begin
                          state_n = ST_START;
                          consume = 1'b1;
                      end
            ST_START: if (start_done) state_n = ST_WAIT;
            ST_WAIT:  if (rise || wd_expire) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            st_cnt        <= '0;
            wd_cnt        <= '0;
            done_q        <= 1'b0;
            out_valid_r   <= 1'b0;
            timeout       <= 1'b0;
            filt_select_r <= FILT_SEL_LPF;
            filt_data_r   <= '0;
            out_data_r    <= '0;
        end else begin
            state       <= state_n;
            done_q      <= bus.filt_done;
            st_cnt      <= (state == ST_START && !start_done) ? st_cnt + SC_W'(1) : '0;
            wd_cnt      <= (state == ST_WAIT && state_n == ST_WAIT) ? wd_cnt + TO_W'(1) : '0;
            out_valid_r <= rise;
            if (state == ST_WAIT && wd_expire && !rise) timeout <= 1'b1;
            else if (clr_status)                        timeout <= 1'b0;
            if (consume) begin
                filt_data_r   <= hold_data;
                filt_select_r <= sel_next(filt_select_r, sel_req);
            end
            if (rise) out_data_r <= bus.filt_result;
        end
    end

    assign bus.filt_start  = (state == ST_START);
    assign bus.filt_select = filt_select_r;
    assign bus.filt_data   = filt_data_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_valid   = out_valid_r;
    assign busy            = (state != ST_IDLE) || hold_full;
endmodule

// File: tb/tb_filt_sched.sv
// Bench for filt_sched: two instances (long watchdog / 16-bit counter and
// short watchdog / 4-bit counter) driven by the same directed vectors.
module tb_filt_sched;
    import filt_pkg::*;

    localparam int START = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clr_status = 1'b0;
    logic [1:0]  sel_req = 2'b00;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = '0;
    logic        filt_done = 1'b0;
    logic [15:0] filt_result = '0;

    logic        busy_a, ovr_a, to_a, busy_b, ovr_b, to_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    filt_sched_if #(.DATA_W(16)) ifa ();
    filt_sched_if #(.DATA_W(16)) ifb ();

    assign ifa.adc_data    = adc_data;
    assign ifa.adc_valid   = adc_valid;
    assign ifa.filt_result = filt_result;
    assign ifa.filt_done   = filt_done;
    assign ifb.adc_data    = adc_data;
    assign ifb.adc_valid   = adc_valid;
    assign ifb.filt_result = filt_result;
    assign ifb.filt_done   = filt_done;

    filt_sched #(.DATA_W(16), .START_CYCLES(START), .TIMEOUT_CYCLES(1024), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .sel_req(sel_req), .clr_status(clr_status),
        .bus(ifa), .busy(busy_a), .overrun(ovr_a), .timeout(to_a), .drop_cnt(cnt_a)
    );

    filt_sched #(.DATA_W(16), .START_CYCLES(START), .TIMEOUT_CYCLES(16), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .sel_req(sel_req), .clr_status(clr_status),
        .bus(ifb), .busy(busy_b), .overrun(ovr_b), .timeout(to_b), .drop_cnt(cnt_b)
    );

    always #4 clk = ~clk;

    // DUT outputs gathered per instance: index 0 = A, 1 = B
    logic        d_start[2], d_ovalid[2], d_busy[2], d_ovr[2], d_to[2];
    logic [1:0]  d_sel[2];
    logic [15:0] d_fdata[2], d_odata[2], d_cnt[2];

    assign d_start[0] = ifa.filt_start;   assign d_start[1] = ifb.filt_start;
    assign d_ovalid[0] = ifa.out_valid;   assign d_ovalid[1] = ifb.out_valid;
    assign d_busy[0] = busy_a;            assign d_busy[1] = busy_b;
    assign d_ovr[0] = ovr_a;              assign d_ovr[1] = ovr_b;
    assign d_to[0] = to_a;                assign d_to[1] = to_b;
    assign d_sel[0] = ifa.filt_select;    assign d_sel[1] = ifb.filt_select;
    assign d_fdata[0] = ifa.filt_data;    assign d_fdata[1] = ifb.filt_data;
    assign d_odata[0] = ifa.out_data;     assign d_odata[1] = ifb.out_data;
    assign d_cnt[0] = cnt_a;              assign d_cnt[1] = {12'b0, cnt_b};

    function automatic int to_limit(input int k);
        return (k == 0) ? 1024 : 16;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a job is either absent or has an age in cycles since
    // it was issued; the start pulse covers ages 0..START-1, waiting follows.
    bit          m_act[2], m_full[2], m_ov[2], m_to[2], m_ovr[2];
    int          m_age[2], m_cnt[2];
    logic [15:0] m_fdata[2], m_hdata[2], m_odata[2];
    logic [1:0]  m_fsel[2];
    bit          m_pdone;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k] <= 0; m_full[k] <= 0; m_ov[k] <= 0; m_to[k] <= 0; m_ovr[k] <= 0;
                m_age[k] <= 0; m_cnt[k] <= 0; m_fdata[k] <= '0; m_hdata[k] <= '0;
                m_odata[k] <= '0; m_fsel[k] <= 2'b00;
            end
            m_pdone <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit issue, waiting, finish, expire, take, drop;
                issue   = !m_act[k] && m_full[k];
                waiting = m_act[k] && (m_age[k] >= START);
                finish  = waiting && filt_done && !m_pdone;
                expire  = waiting && !finish && (m_age[k] - START == to_limit(k) - 1);
                take    = adc_valid && enable;
                drop    = take && m_full[k] && !issue;

                m_ov[k] <= finish;
                if (finish) m_odata[k] <= filt_result;
                if (expire) m_to[k] <= 1;
                else if (clr_status) m_to[k] <= 0;

                if (take && (!m_full[k] || issue)) begin
                    m_full[k]  <= 1;
                    m_hdata[k] <= adc_data;
                end else if (issue) m_full[k] <= 0;

                if (drop) begin
                    m_ovr[k] <= 1;
                    m_cnt[k] <= clr_status ? 1 : ((m_cnt[k] >= cnt_max(k)) ? cnt_max(k) : m_cnt[k] + 1);
                end else if (clr_status) begin
                    m_ovr[k] <= 0;
                    m_cnt[k] <= 0;
                end

                if (issue) begin
                    m_act[k]   <= 1;
                    m_age[k]   <= 0;
                    m_fdata[k] <= m_hdata[k];
                    if (sel_req != 2'b11) m_fsel[k] <= sel_req;
                end else if (finish || expire) m_act[k] <= 0;
                else if (m_act[k]) m_age[k] <= m_age[k] + 1;
            end
            m_pdone <= filt_done;
        end
    end

    // Single compare process, mid-cycle on the falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            string nm;
            nm = (k == 0) ? "A" : "B";
            chk({nm, ".filt_start"},  32'(d_start[k]),  32'(m_act[k] && m_age[k] < START));
            chk({nm, ".out_valid"},   32'(d_ovalid[k]), 32'(m_ov[k]));
            chk({nm, ".busy"},        32'(d_busy[k]),   32'(m_act[k] || m_full[k]));
            chk({nm, ".overrun"},     32'(d_ovr[k]),    32'(m_ovr[k]));
            chk({nm, ".timeout"},     32'(d_to[k]),     32'(m_to[k]));
            chk({nm, ".filt_select"}, 32'(d_sel[k]),    32'(m_fsel[k]));
            chk({nm, ".filt_data"},   32'(d_fdata[k]),  32'(m_fdata[k]));
            chk({nm, ".out_data"},    32'(d_odata[k]),  32'(m_odata[k]));
            chk({nm, ".drop_cnt"},    32'(d_cnt[k]),    32'(m_cnt[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        adc_valid = 1'b1;
        adc_data  = v;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] r);
        filt_result = r;
        filt_done   = 1'b1;
        tick();
        filt_done   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        tick(); tick(); tick();
        chk("rst.busy",        32'(busy_a), 32'd0);
        chk("rst.out_valid",   32'(ifa.out_valid), 32'd0);
        chk("rst.filt_start",  32'(ifa.filt_start), 32'd0);
        chk("rst.filt_select", 32'(ifa.filt_select), 32'd0);
        chk("rst.drop_cnt",    32'(cnt_a), 32'd0);
        rst = 1'b0;
        enable = 1'b1;

        // Single sample through the filter, HPF selected
        sel_req = 2'b01;
        send(16'd1234);
        chk("t1.busy_after_capture", 32'(busy_a), 32'd1);
        chk("t1.start_not_yet",      32'(ifa.filt_start), 32'd0);
        tick();
        chk("t1.start_cycle1",  32'(ifa.filt_start), 32'd1);
        chk("t1.filt_data",     32'(ifa.filt_data), 32'd1234);
        chk("t1.filt_select",   32'(ifa.filt_select), 32'd1);
        tick();
        chk("t1.start_cycle2",  32'(ifa.filt_start), 32'd1);
        tick();
        chk("t1.start_ended",   32'(ifa.filt_start), 32'd0);
        repeat (19) tick();
        pulse_done(16'd567);
        chk("t1.out_valid",     32'(ifa.out_valid), 32'd1);
        chk("t1.out_data",      32'(ifa.out_data), 32'd567);
        tick();
        chk("t1.out_valid_one", 32'(ifa.out_valid), 32'd0);
        chk("t1.busy_idle",     32'(busy_a), 32'd0);

        // Three back-to-back samples: two processed in order, third dropped
        do_reset();
        sel_req = 2'b00;
        adc_valid = 1'b1;
        adc_data = 16'd10; tick();
        adc_data = 16'd20; tick();
        adc_data = 16'd30; tick();
        adc_valid = 1'b0;
        chk("t2.overrun",     32'(ovr_a), 32'd1);
        chk("t2.drop_cnt",    32'(cnt_a), 32'd1);
        chk("t2.first_data",  32'(ifa.filt_data), 32'd10);
        repeat (50) tick();
        pulse_done(16'd111);
        chk("t2.out1",        32'(ifa.out_data), 32'd111);
        tick();
        chk("t2.second_data", 32'(ifa.filt_data), 32'd20);
        chk("t2.second_start", 32'(ifa.filt_start), 32'd1);
        repeat (50) tick();
        pulse_done(16'd222);
        chk("t2.out2",        32'(ifa.out_data), 32'd222);
        tick();
        chk("t2.busy_idle",   32'(busy_a), 32'd0);
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("t2.clr_overrun", 32'(ovr_a), 32'd0);
        chk("t2.clr_cnt",     32'(cnt_a), 32'd0);

        // Select latched only at issue; reserved code keeps the old select
        do_reset();
        sel_req = 2'b00;
        send(16'd5);
        tick();
        chk("t3.sel_lpf",       32'(ifa.filt_select), 32'd0);
        sel_req = 2'b10;
        repeat (4) tick();
        chk("t3.sel_held",      32'(ifa.filt_select), 32'd0);
        pulse_done(16'd55);
        tick();
        send(16'd6);
        tick();
        chk("t3.sel_bpf",       32'(ifa.filt_select), 32'd2);
        chk("t3.data6",         32'(ifa.filt_data), 32'd6);
        repeat (3) tick();
        pulse_done(16'd66);
        tick();
        sel_req = 2'b11;
        send(16'd7);
        tick();
        chk("t3.sel_rsv_keeps", 32'(ifa.filt_select), 32'd2);
        chk("t3.data7",         32'(ifa.filt_data), 32'd7);
        repeat (3) tick();
        pulse_done(16'd77);
        tick();

        // Watchdog on instance B (16 wait cycles), held sample follows
        do_reset();
        sel_req = 2'b00;
        send(16'd100);
        send(16'd200);
        repeat (17) tick();
        chk("t4.no_timeout_yet", 32'(to_b), 32'd0);
        tick();
        chk("t4.timeout",        32'(to_b), 32'd1);
        chk("t4.no_out_valid",   32'(ifb.out_valid), 32'd0);
        tick();
        chk("t4.next_data",      32'(ifb.filt_data), 32'd200);
        chk("t4.next_start",     32'(ifb.filt_start), 32'd1);
        pulse_done(16'd77);
        chk("t4.a_out",          32'(ifa.out_data), 32'd77);
        repeat (4) tick();
        pulse_done(16'd88);
        chk("t4.b_out_valid",    32'(ifb.out_valid), 32'd1);
        chk("t4.b_out_data",     32'(ifb.out_data), 32'd88);
        tick();
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        chk("t4.clr_timeout",    32'(to_b), 32'd0);

        // Async reset mid-wait, then a done edge that must be ignored
        do_reset();
        sel_req = 2'b01;
        send(16'd300);
        repeat (5) tick();
        #1 rst = 1'b1;
        #1;
        chk("t5.busy",        32'(busy_a), 32'd0);
        chk("t5.filt_data",   32'(ifa.filt_data), 32'd0);
        chk("t5.filt_select", 32'(ifa.filt_select), 32'd0);
        tick();
        rst = 1'b0;
        pulse_done(16'd999);
        chk("t5.no_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("t5.out_data",     32'(ifa.out_data), 32'd0);
        enable = 1'b0;
        send(16'd1); send(16'd2); send(16'd3);
        tick();
        chk("t5.dis_busy",     32'(busy_a), 32'd0);
        chk("t5.dis_cnt",      32'(cnt_a), 32'd0);
        enable = 1'b1;

        // Drop counter saturation on instance B, then clear coincident with drop
        do_reset();
        adc_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            adc_data = 16'(i + 1);
            tick();
        end
        chk("t6.sat_cnt",     32'(cnt_b), 32'd15);
        chk("t6.sat_overrun", 32'(ovr_b), 32'd1);
        clr_status = 1'b1;
        adc_data = 16'd99;
        tick();
        clr_status = 1'b0;
        adc_valid = 1'b0;
        chk("t6.clr_drop_cnt",     32'(cnt_b), 32'd1);
        chk("t6.clr_drop_overrun", 32'(ovr_b), 32'd1);
        chk("t6.clr_drop_cnt_a",   32'(cnt_a), 32'd1);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
